// File: rtl/rand_pattern_if.sv
// Request/response bundle between a pattern consumer (master) and the
// pattern generator (slave).
interface rand_pattern_if #(
    parameter int WIDTH = 18
);
    logic             start;
    logic [WIDTH-1:0] rand_out;
    logic             valid;
    logic             busy;
    logic             fallback;

    modport master (output start, input rand_out, valid, busy, fallback);
    modport slave  (input start, output rand_out, valid, busy, fallback);
endinterface

// File: rtl/rand_pattern_gen.sv
// Popcount-constrained, no-repeat pseudo-random pattern generator driven by a
// free-running Galois LFSR, with a bounded retry budget and a fixed fallback.
module rand_pattern_gen #(
    parameter int                WIDTH     = 18,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MIN_ONES  = 4,
    parameter int                MAX_ONES  = 6,
    parameter int                MAX_TRIES = 15,
    parameter logic [WIDTH-1:0]  FALLBACK  = 18'b000000000000001111
) (
    input  logic          clk,
    input  logic          reset_n,
    rand_pattern_if.slave bus
);
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [POP_W-1:0] MIN_P    = POP_W'(MIN_ONES);
    localparam logic [POP_W-1:0] MAX_P    = POP_W'(MAX_ONES);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GEN, S_HOLD} state_t;

    state_t             state_q,    state_d;
    logic [LFSR_W-1:0]  lfsr_q,     lfsr_d;
    logic               start_q,    start_d;
    logic [TRY_W-1:0]   tries_q,    tries_d;
    logic [WIDTH-1:0]   rand_out_q, rand_out_d;
    logic [WIDTH-1:0]   last_out_q, last_out_d;
    logic               valid_q,    valid_d;
    logic               fallback_q, fallback_d;

    logic [WIDTH-1:0]   cand_c;
    logic [POP_W-1:0]   pop_c;
    logic               accept_c;
    logic               rise_c;
    logic               fall_c;

    // Candidate replicates the LFSR bits cyclically when WIDTH > LFSR_W.
    always_comb begin
        cand_c = '0;
        pop_c  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand_c[i] = lfsr_q[i % LFSR_W];
            pop_c     = pop_c + POP_W'(cand_c[i]);
        end
        accept_c = (pop_c >= MIN_P) && (pop_c <= MAX_P) && (cand_c != last_out_q);
    end

    always_comb begin
        rise_c     = bus.start & ~start_q;
        fall_c     = ~bus.start & start_q;
        lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        start_d    = bus.start;
        state_d    = state_q;
        tries_d    = tries_q;
        rand_out_d = rand_out_q;
        last_out_d = last_out_q;
        valid_d    = 1'b0;
        fallback_d = fallback_q;
        case (state_q)
            S_IDLE: begin
                if (rise_c) begin
                    state_d = S_GEN;
                    tries_d = '0;
                end
            end
            S_GEN: begin
                // A release pre-empts the evaluation scheduled for this edge.
                if (fall_c) begin
                    state_d    = S_IDLE;
                    rand_out_d = '0;
                    fallback_d = 1'b0;
                end else if (accept_c) begin
                    state_d    = S_HOLD;
                    rand_out_d = cand_c;
                    last_out_d = cand_c;
                    valid_d    = 1'b1;
                    fallback_d = 1'b0;
                end else if (tries_q == LAST_TRY) begin
                    state_d    = S_HOLD;
                    rand_out_d = FALLBACK;
                    last_out_d = FALLBACK;
                    valid_d    = 1'b1;
                    fallback_d = 1'b1;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            S_HOLD: begin
                if (fall_c) begin
                    state_d    = S_IDLE;
                    rand_out_d = '0;
                    fallback_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            start_q    <= 1'b0;
            tries_q    <= '0;
            rand_out_q <= '0;
            last_out_q <= '0;
            valid_q    <= 1'b0;
            fallback_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            start_q    <= start_d;
            tries_q    <= tries_d;
            rand_out_q <= rand_out_d;
            last_out_q <= last_out_d;
            valid_q    <= valid_d;
            fallback_q <= fallback_d;
        end
    end

    assign bus.rand_out = rand_out_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = (state_q == S_GEN);
    assign bus.fallback = fallback_q;
endmodule

// File: tb/tb_rand_pattern_gen.sv
// Directed bench for rand_pattern_gen: default, forced-fallback and
// abort-mid-generation configurations driven side by side.
module tb_rand_pattern_gen;
    localparam int W = 18;
    localparam logic [W-1:0] FB = 18'b000000000000001111;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    logic [15:0]  m_lfsr;
    logic [W-1:0] exp_last;

    rand_pattern_if #(.WIDTH(W)) def_if ();
    rand_pattern_if #(.WIDTH(W)) fb_if ();
    rand_pattern_if #(.WIDTH(W)) ab_if ();

    rand_pattern_gen u_def (.clk(clk), .reset_n(reset_n), .bus(def_if));

    rand_pattern_gen #(.MIN_ONES(0), .MAX_ONES(0), .MAX_TRIES(4))
        u_fb (.clk(clk), .reset_n(reset_n), .bus(fb_if));

    rand_pattern_gen #(.MIN_ONES(0), .MAX_ONES(0), .MAX_TRIES(15))
        u_ab (.clk(clk), .reset_n(reset_n), .bus(ab_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic logic [W-1:0] cand_of(input logic [15:0] l);
        logic [W-1:0] c;
        for (int i = 0; i < W; i++) c[i] = l[i % 16];
        return c;
    endfunction

    // Reference LFSR running alongside the default instance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic test_reset;
        reset_n = 1'b0;
        def_if.start = 1'b0;
        fb_if.start  = 1'b0;
        ab_if.start  = 1'b0;
        #3;
        total++;
        if ({def_if.rand_out, def_if.valid, def_if.busy, def_if.fallback} !== '0) begin
            bad++;
            $display("FAIL reset_state: got out=%h v=%b b=%b f=%b want all 0",
                     def_if.rand_out, def_if.valid, def_if.busy, def_if.fallback);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        ab_if.start = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ab_if.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_gen: got busy=%b want 1", ab_if.busy);
        end
        #2;
        reset_n = 1'b0;
        ab_if.start = 1'b0;
        #1;
        total++;
        if ({ab_if.rand_out, ab_if.valid, ab_if.busy, ab_if.fallback} !== '0) begin
            bad++;
            $display("FAIL reset_async: got out=%h v=%b b=%b f=%b want all 0",
                     ab_if.rand_out, ab_if.valid, ab_if.busy, ab_if.fallback);
        end
        total++;
        if (u_def.lfsr_q !== 16'hACE1) begin
            bad++;
            $display("FAIL reset_seed: got %h want ace1", u_def.lfsr_q);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (u_def.lfsr_q !== 16'hE270) begin
            bad++;
            $display("FAIL lfsr_first_step: got %h want e270", u_def.lfsr_q);
        end
        @(negedge clk);
        repeat (5) begin
            total++;
            if ({ab_if.valid, ab_if.busy, ab_if.rand_out} !== '0) begin
                bad++;
                $display("FAIL reset_quiet: got v=%b b=%b out=%h want 0",
                         ab_if.valid, ab_if.busy, ab_if.rand_out);
            end
            @(negedge clk);
        end
        exp_last = '0;
    endtask

    // Called at a negedge; raises start, tracks the expected load cycle from
    // the reference LFSR, holds, releases, and returns at a negedge.
    task automatic do_request(input int hold);
        logic [15:0]  l;
        logic [W-1:0] c;
        logic [W-1:0] exp_pat;
        logic [W-1:0] prev;
        logic         exp_fb;
        int           exp_j;
        prev = exp_last;
        def_if.start = 1'b1;
        @(negedge clk);
        total++;
        if ({def_if.busy, def_if.valid} !== 2'b10) begin
            bad++;
            $display("FAIL gen_entry: got busy=%b valid=%b want 1 0", def_if.busy, def_if.valid);
        end
        l = m_lfsr;
        exp_j = 0;
        exp_pat = FB;
        exp_fb = 1'b1;
        for (int j = 1; j <= 15; j++) begin
            c = cand_of(l);
            if ($countones(c) >= 4 && $countones(c) <= 6 && c !== prev) begin
                exp_j = j;
                exp_pat = c;
                exp_fb = 1'b0;
                break;
            end
            l = lfsr_step(l);
        end
        if (exp_j == 0) exp_j = 15;
        for (int j = 1; j < exp_j; j++) begin
            @(negedge clk);
            total++;
            if ({def_if.valid, def_if.busy} !== 2'b01) begin
                bad++;
                $display("FAIL gen_wait: cycle %0d got valid=%b busy=%b want 0 1",
                         j, def_if.valid, def_if.busy);
            end
        end
        @(negedge clk);
        total++;
        if ({def_if.valid, def_if.busy, def_if.fallback, def_if.rand_out} !==
            {1'b1, 1'b0, exp_fb, exp_pat}) begin
            bad++;
            $display("FAIL load: got v=%b b=%b f=%b out=%h want 1 0 %b %h (cycle %0d)",
                     def_if.valid, def_if.busy, def_if.fallback, def_if.rand_out,
                     exp_fb, exp_pat, exp_j);
        end
        if (!exp_fb) begin
            total++;
            if (def_if.rand_out === prev) begin
                bad++;
                $display("FAIL no_repeat: got %h equal to previous %h", def_if.rand_out, prev);
            end
            total++;
            if ($countones(def_if.rand_out) < 4 || $countones(def_if.rand_out) > 6) begin
                bad++;
                $display("FAIL popcount: got %0d ones in %h want 4..6",
                         $countones(def_if.rand_out), def_if.rand_out);
            end
        end
        exp_last = exp_pat;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            total++;
            if ({def_if.valid, def_if.rand_out} !== {1'b0, exp_pat}) begin
                bad++;
                $display("FAIL hold: got v=%b out=%h want 0 %h", def_if.valid, def_if.rand_out, exp_pat);
            end
        end
        def_if.start = 1'b0;
        @(negedge clk);
        total++;
        if ({def_if.rand_out, def_if.valid, def_if.busy, def_if.fallback} !== '0) begin
            bad++;
            $display("FAIL release: got out=%h v=%b b=%b f=%b want all 0",
                     def_if.rand_out, def_if.valid, def_if.busy, def_if.fallback);
        end
    endtask

    task automatic test_normal;
        do_request(40);
    endtask

    task automatic test_abort;
        def_if.start = 1'b1;
        @(negedge clk);
        def_if.start = 1'b0;
        @(negedge clk);
        total++;
        if ({def_if.rand_out, def_if.valid, def_if.busy, def_if.fallback} !== '0) begin
            bad++;
            $display("FAIL abort_idle: got out=%h v=%b b=%b f=%b want all 0",
                     def_if.rand_out, def_if.valid, def_if.busy, def_if.fallback);
        end
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({def_if.valid, def_if.rand_out} !== '0) begin
                bad++;
                $display("FAIL abort_quiet: got v=%b out=%h want 0", def_if.valid, def_if.rand_out);
            end
        end
        total++;
        if (u_def.last_out_q !== exp_last) begin
            bad++;
            $display("FAIL abort_last: got %h want %h", u_def.last_out_q, exp_last);
        end
    endtask

    task automatic test_back_to_back;
        repeat (200) do_request(0);
    endtask

    task automatic test_fallback;
        fb_if.start = 1'b1;
        @(negedge clk);
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            total++;
            if ({fb_if.valid, fb_if.busy} !== 2'b01) begin
                bad++;
                $display("FAIL fb_wait: cycle %0d got valid=%b busy=%b want 0 1", j, fb_if.valid, fb_if.busy);
            end
        end
        @(negedge clk);
        total++;
        if ({fb_if.valid, fb_if.fallback, fb_if.busy, fb_if.rand_out} !== {1'b1, 1'b1, 1'b0, FB}) begin
            bad++;
            $display("FAIL fb_load: got v=%b f=%b b=%b out=%h want 1 1 0 %h",
                     fb_if.valid, fb_if.fallback, fb_if.busy, fb_if.rand_out, FB);
        end
        @(negedge clk);
        total++;
        if ({fb_if.valid, fb_if.fallback, fb_if.busy, fb_if.rand_out} !== {1'b0, 1'b1, 1'b0, FB}) begin
            bad++;
            $display("FAIL fb_hold: got v=%b f=%b b=%b out=%h want 0 1 0 %h",
                     fb_if.valid, fb_if.fallback, fb_if.busy, fb_if.rand_out, FB);
        end
        fb_if.start = 1'b0;
        @(negedge clk);
        total++;
        if ({fb_if.rand_out, fb_if.valid, fb_if.busy, fb_if.fallback} !== '0) begin
            bad++;
            $display("FAIL fb_release: got out=%h v=%b b=%b f=%b want all 0",
                     fb_if.rand_out, fb_if.valid, fb_if.busy, fb_if.fallback);
        end
    endtask

    task automatic test_abort_gen;
        ab_if.start = 1'b1;
        @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({ab_if.valid, ab_if.busy} !== 2'b01) begin
                bad++;
                $display("FAIL abgen_wait: got valid=%b busy=%b want 0 1", ab_if.valid, ab_if.busy);
            end
        end
        ab_if.start = 1'b0;
        @(negedge clk);
        total++;
        if ({ab_if.rand_out, ab_if.valid, ab_if.busy, ab_if.fallback} !== '0) begin
            bad++;
            $display("FAIL abgen_drop: got out=%h v=%b b=%b f=%b want all 0",
                     ab_if.rand_out, ab_if.valid, ab_if.busy, ab_if.fallback);
        end
        ab_if.start = 1'b1;
        @(negedge clk);
        for (int j = 1; j < 15; j++) begin
            @(negedge clk);
            total++;
            if ({ab_if.valid, ab_if.busy} !== 2'b01) begin
                bad++;
                $display("FAIL abgen_retry: cycle %0d got valid=%b busy=%b want 0 1",
                         j, ab_if.valid, ab_if.busy);
            end
        end
        @(negedge clk);
        total++;
        if ({ab_if.valid, ab_if.fallback, ab_if.busy, ab_if.rand_out} !== {1'b1, 1'b1, 1'b0, FB}) begin
            bad++;
            $display("FAIL abgen_fb: got v=%b f=%b b=%b out=%h want 1 1 0 %h",
                     ab_if.valid, ab_if.fallback, ab_if.busy, ab_if.rand_out, FB);
        end
        ab_if.start = 1'b0;
        @(negedge clk);
        total++;
        if ({ab_if.rand_out, ab_if.valid, ab_if.busy, ab_if.fallback} !== '0) begin
            bad++;
            $display("FAIL abgen_release: got out=%h v=%b b=%b f=%b want all 0",
                     ab_if.rand_out, ab_if.valid, ab_if.busy, ab_if.fallback);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_last = '0;
        test_reset();
        test_normal();
        test_abort();
        test_back_to_back();
        test_fallback();
        test_abort_gen();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end
endmodule
